// File: rtl/avr_irq_ctrl_if.sv
// avr_irq_ctrl_if: IO-bus window between the AVR core and the interrupt
// controller register file (strobes pre-qualified by the top-level decode).
interface avr_irq_ctrl_if;
  logic       io_re;
  logic       io_we;
  logic [1:0] io_a;
  logic [7:0] io_din;
  logic [7:0] io_dout;

  // Core side drives strobes, address and write data.
  modport master (output io_re, io_we, io_a, io_din, input io_dout);
  // Controller side answers reads.
  modport slave  (input io_re, io_we, io_a, io_din, output io_dout);
endinterface

// File: rtl/avr_irq_ctrl.sv
// avr_irq_ctrl: latches, masks and prioritises peripheral IRQ lines and
// offers one vector at a time to the AVR core until it is acknowledged.
// Optional feature macro: AVR_IRQ_CTRL_EDGE_EN adds per-line rising-edge
// latching, the IEDGE register and write-1-to-clear on IPND. Without it every
// line is level mode, IEDGE reads 0 and IPND writes are ignored.
module avr_irq_ctrl #(
  parameter int NUM_VECTORS = 4,
  parameter int VECT_W      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  avr_irq_ctrl_if.slave          bus,
  input  logic [NUM_VECTORS-1:0] irq_lines,
  input  logic                   iack,
  output logic                   iflag,
  output logic [VECT_W-1:0]      ivect
);

  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

  state_t                   state_reg, state_next;
  logic [VECT_W-1:0]        ivect_reg, ivect_next;
  logic [NUM_VECTORS-1:0]   imsk_reg;
  logic [NUM_VECTORS-1:0]   pnd_reg, pnd_next;
  logic [NUM_VECTORS-1:0]   iedge_val;
  logic [NUM_VECTORS-1:0]   cand;
  logic [VECT_W-1:0]        winner;
  logic                     wr_imsk;
  logic [7:0]               rd_word;
  logic                     unused_din;

  assign wr_imsk    = bus.io_we && (bus.io_a == 2'd0);
  assign cand       = pnd_reg & imsk_reg;
  // High write-data bits beyond the line count are simply dropped.
  assign unused_din = ^bus.io_din;

`ifdef AVR_IRQ_CTRL_EDGE_EN
  logic [NUM_VECTORS-1:0] prev_reg;
  logic [NUM_VECTORS-1:0] iedge_reg;
  logic [NUM_VECTORS-1:0] ack_clr;
  logic                   wr_ipnd;
  logic                   wr_iedge;

  assign wr_ipnd   = bus.io_we && (bus.io_a == 2'd1);
  assign wr_iedge  = bus.io_we && (bus.io_a == 2'd2);
  assign iedge_val = iedge_reg;

  // Previous line sample for rising-edge detection, plus the mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg  <= '0;
      iedge_reg <= '0;
    end else begin
      prev_reg <= irq_lines;
      if (wr_iedge)
        iedge_reg <= bus.io_din[NUM_VECTORS-1:0];
    end
  end

  // One-hot clear for the line the core just took.
  always_comb begin
    ack_clr = '0;
    if (state_reg == ST_OFFER && iack)
      ack_clr[ivect_reg] = 1'b1;
  end

  // Per-line capture: edge lines latch and a new edge beats any clear;
  // level lines just follow the input.
  generate
    for (genvar gi = 0; gi < NUM_VECTORS; gi++) begin : g_pnd
      assign pnd_next[gi] = iedge_reg[gi]
        ? ((irq_lines[gi] & ~prev_reg[gi]) |
           (pnd_reg[gi] & ~((wr_ipnd & bus.io_din[gi]) | ack_clr[gi])))
        : irq_lines[gi];
    end
  endgenerate
`else
  assign iedge_val = '0;

  // Level-only build: pending simply follows each line one cycle late.
  generate
    for (genvar gi = 0; gi < NUM_VECTORS; gi++) begin : g_pnd
      assign pnd_next[gi] = irq_lines[gi];
    end
  endgenerate
`endif

  // Pending and mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pnd_reg  <= '0;
      imsk_reg <= '0;
    end else begin
      pnd_reg <= pnd_next;
      if (wr_imsk)
        imsk_reg <= bus.io_din[NUM_VECTORS-1:0];
    end
  end

  // Fixed priority: lowest index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--)
      if (cand[i])
        winner = VECT_W'(i);
  end

  // Offer FSM state and the frozen vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ivect_reg <= '0;
    end else begin
      state_reg <= state_next;
      ivect_reg <= ivect_next;
    end
  end

  // Next state: IDLE latches the winner; OFFER holds until the core takes
  // it or the offered request vanishes (W1C or level drop).
  always_comb begin
    state_next = state_reg;
    ivect_next = ivect_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|cand) begin
          state_next = ST_OFFER;
          ivect_next = winner;
        end
      end
      ST_OFFER: begin
        if (iack || !pnd_reg[ivect_reg])
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Core-facing outputs follow the FSM state and the frozen vector.
  always_comb begin
    iflag = (state_reg == ST_OFFER);
    ivect = ivect_reg;
  end

  // Combinational register read; returns pre-write contents on a
  // same-cycle write, and 0 whenever no read is strobed.
  always_comb begin
    rd_word = '0;
    if (bus.io_re) begin
      case (bus.io_a)
        2'd0: rd_word[NUM_VECTORS-1:0] = imsk_reg;
        2'd1: rd_word[NUM_VECTORS-1:0] = pnd_reg;
        2'd2: rd_word[NUM_VECTORS-1:0] = iedge_val;
        default: begin
          rd_word[7]        = iflag;
          rd_word[VECT_W-1:0] = ivect_reg;
        end
      endcase
    end
  end

  assign bus.io_dout = rd_word;

endmodule

// File: doc/avr_irq_ctrl.md
# avr_irq_ctrl

Memory-mapped interrupt controller between the peripheral IRQ lines (timer0, uart0, spare) and the AVR core's `iflag`/`ivect` inputs. It latches, masks and prioritises requests, then holds one vector stable until the core acknowledges it. Software can read and clear pending requests through a 4-register window on the IO bus.

## Interface
Parameters:
- `NUM_VECTORS`, default 4: IRQ lines, 2..8.
- `VECT_W`, default 2: vector width; must equal clog2(`NUM_VECTORS`).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: **synchronous, active-high** reset.
- `io_re` in 1: IO read strobe, pre-qualified by the top-level address select.
- `io_we` in 1: IO write strobe, pre-qualified.
- `io_a` in 2: register index.
- `io_din` in 8: write data from the core.
- `io_dout` out 8: read data to the core. Driven only while `io_re` is high, otherwise 0.
- `irq_lines` in `NUM_VECTORS`: requests, synchronous to `clk`, active-high.
- `iack` in 1: one-cycle pulse from the core when it takes the vector.
- `iflag` out 1: an interrupt is offered to the core.
- `ivect` out `VECT_W`: index of the offered interrupt.

## Operation
Register map (unused high bits read 0 and ignore writes):
- 0 IMSK, R/W: per-line enable.
- 1 IPND, R/W1C: pending bits. Writing 1 clears an edge-mode bit; level-mode bits ignore writes.
- 2 IEDGE, R/W: 1 selects rising-edge latched mode, 0 selects level mode.
- 3 ISTAT, read-only: bit7 = `iflag`, bits[VECT_W-1:0] = `ivect`.

Request capture:
- `prev` register samples `irq_lines` every cycle.
- Edge-mode line i: `pnd[i]` is set when `irq_lines[i] & ~prev[i]`. It stays set until cleared by W1C or by `iack` on vector i.
- Level-mode line i: `pnd[i] <= irq_lines[i]` every cycle.

Arbitration:
- Candidate set is `pnd & IMSK`. The lowest index has the highest priority.

Offer FSM, two states:
- IDLE: `iflag` = 0. If the candidate set is non-zero, register `ivect` = winner and `iflag` = 1, then go to OFFER.
- OFFER: `iflag` and `ivect` are frozen, even if higher-priority requests arrive or the offered line's mask is removed.
  - On `iack`: clear `pnd[ivect]` if that line is edge mode, drop `iflag`, go to IDLE.
  - IDLE must last at least one cycle before the next offer.
  - If the offered bit is cleared by W1C or a level drop without `iack`, also return to IDLE and drop `iflag`. No spurious vector is held.

Simultaneous events:
- A new edge and a W1C or `iack` clear on the same bit in the same cycle: set wins.
- A write and a read to the same register in the same cycle: the read returns the old value.

Reset values: IMSK, IPND, IEDGE, `prev` = 0; `iflag` = 0; `ivect` = 0; FSM in IDLE; `io_dout` = 0.

Reset asserted mid-offer: all state is cleared on the next edge and `iflag` drops. Edges that occur during reset are lost.

## Timing
- `irq_lines` rising at cycle n → `pnd` set at n+1 → `iflag`/`ivect` valid at n+2. Same latency for level mode.
- `iack` at cycle m → `iflag` = 0 at m+1 → earliest re-offer at m+2.
- IO reads are combinational, same cycle. IO writes take effect at the next edge.
- `ivect` must never change while `iflag` = 1.

## Configuration
- `AVR_IRQ_CTRL_EDGE_EN` defined: edge latching and the IEDGE register are present, as described above.
- Not defined: every line is level mode; IEDGE reads 0 and ignores writes; IPND writes are ignored. This removes `prev` and the W1C logic.

## Test plan
- Reset, then read all four registers → each reads 0x00; `iflag` = 0.
- IMSK = 0x0F, IEDGE = 0; hold `irq_lines` = 4'b0100 → `iflag` = 1, `ivect` = 2 two cycles later. Pulse `iack` → `iflag` = 0 for exactly one cycle, then the line is re-offered with `ivect` = 2.
- IEDGE = 0x0F; pulse line 1 for one cycle → IPND reads 0x02, `ivect` = 1. Pulse line 0 while in OFFER → `ivect` stays 1. `iack` → IPND = 0x01, then `ivect` = 0 is offered.
- IMSK = 0x00; edge on line 3 → IPND = 0x08, `iflag` stays 0. Write IPND = 0x08 → IPND = 0x00. Assert a new edge in the same cycle as that W1C → IPND stays 0x08.
- With `iflag` = 1 and `ivect` = 2, assert `rst` for one cycle → `iflag` = 0, all registers read 0x00, and `pnd` stays clear afterwards.
- Build without `AVR_IRQ_CTRL_EDGE_EN`: write IEDGE = 0xFF → reads 0x00; a one-cycle pulse on line 1 yields `iflag` for exactly one cycle, 2 cycles after the pulse.
